// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// ----------------------------------------------------------------------------
// Memory-stage access controller. Converts single-cycle MEM-stage load/store
// intents into held request/ready transactions toward a variable-latency data
// memory, freezes the pipeline via StallM while an access is outstanding, and
// aborts (sticky MemErr) when memory does not answer within TIMEOUT cycles.
//
// Optional feature macro: STORE_BUFFER_EN
//   defined   -> one-entry posted store buffer; a store issued from IDLE does
//                not stall, and drains in the background.
//   undefined -> every load and store blocks until completion.
//
// Parameters
//   TIMEOUT     max REQ cycles without MemReady before abort (1..65535)
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   MemReadM/MemWriteM   load/store intent in MEM stage
//   ALUResultM           byte address (bits [1:0] ignored)
//   WriteDataM           store data
//   ReadDataM            registered load result
//   StallM               combinational pipeline freeze request
//   MemReq/MemWe         registered request and direction (1 = write)
//   MemAddr/MemWData     word address / write data, held while MemReq
//   MemRData/MemReady    memory read data and completion
//   MemErr               sticky timeout flag, cleared only by reset
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a load/store; captures address, data and direction
// REQ    | MemReq held high until MemReady or timeout
// DONE   | access finished; pipeline released, inputs not re-sampled
// ----------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic        MemErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Abort fires in the REQ cycle whose counter already holds TIMEOUT-1
    // without MemReady, so MemReq stays high for exactly TIMEOUT cycles.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [31:0] RDATA_ERR = 32'hDEAD_BEEF;

    state_t      state_q,     state_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        mem_err_q,   mem_err_d;
    logic [15:0] wait_cnt_q,  wait_cnt_d;
    // Set while the current transaction is a posted store drain.
    logic        posted_q,    posted_d;

    logic        access;
    logic        stall;

    assign access = MemReadM | MemWriteM;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_err_d   = mem_err_q;
        wait_cnt_d  = wait_cnt_q;
        posted_d    = posted_q;
        stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    // Read+write together resolves to a write.
                    mem_we_d    = MemWriteM;
                    mem_addr_d  = ALUResultM & 32'hFFFF_FFFC;
                    mem_wdata_d = WriteDataM;
                    mem_req_d   = 1'b1;
                    wait_cnt_d  = 16'd0;
                    state_d     = ST_REQ;
`ifdef STORE_BUFFER_EN
                    posted_d    = MemWriteM;
                    stall       = ~MemWriteM;
`else
                    posted_d    = 1'b0;
                    stall       = 1'b1;
`endif
                end
            end

            ST_REQ: begin
                // A posted drain only holds back a new access waiting behind it.
                stall = posted_q ? access : 1'b1;
                if (MemReady) begin
                    if (!mem_we_q) begin
                        rdata_d = MemRData;
                    end
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    if (!mem_we_q) begin
                        rdata_d = RDATA_ERR;
                    end
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            ST_DONE: begin
                // After a drain, the access that was waiting is still in MEM and
                // must stay frozen until IDLE picks it up next cycle.
                stall    = posted_q & access;
                posted_d = 1'b0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                posted_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            mem_err_q   <= 1'b0;
            wait_cnt_q  <= 16'd0;
            posted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            mem_err_q   <= mem_err_d;
            wait_cnt_q  <= wait_cnt_d;
            posted_q    <= posted_d;
        end
    end

    assign StallM    = stall;
    assign MemReq    = mem_req_q;
    assign MemWe     = mem_we_q;
    assign MemAddr   = mem_addr_q;
    assign MemWData  = mem_wdata_q;
    assign ReadDataM = rdata_q;
    assign MemErr    = mem_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit
// Directed bench for dmem_access_unit (TIMEOUT = 4). Inputs are driven 1 ns
// after the rising edge; outputs are sampled on the falling edge. A small
// memory responder raises MemReady after a chosen number of REQ wait cycles.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [31:0] MemRData;
    logic        MemReady;
    logic        MemErr;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    dmem_access_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemRData   (MemRData),
        .MemReady   (MemReady),
        .MemErr     (MemErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemReadM = 1'b0; MemWriteM = 1'b0; MemReady = 1'b0; MemRData = JUNK;
            @(negedge clk);
        end
    endtask

    // Holds the access on the inputs while StallM is high (frozen pipeline);
    // returns once a non-stalled cycle (DONE) has been observed.
    // waits < 0 means memory never answers.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rresp, input int waits,
                             output int stalls, output int reqs);
        int  cyc;
        int  seen;
        bit  done;
        logic [31:0] exp_addr;
        exp_addr = addr;
        exp_addr[1:0] = 2'b00;
        stalls = 0; reqs = 0; seen = 0; done = 1'b0; cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wdata;
            MemReady = 1'b0; MemRData = JUNK;
            if (MemReq) begin
                reqs++;
                check({tag, "_addr"}, MemAddr, exp_addr);
                check({tag, "_we"}, {31'd0, MemWe}, {31'd0, wr});
                if (wr) check({tag, "_wdata"}, MemWData, wdata);
                if (waits >= 0 && seen == waits) begin
                    MemReady = 1'b1;
                    MemRData = rresp;
                end
                seen++;
            end
            @(negedge clk);
            if (StallM) stalls++;
            else if (cyc > 0) done = 1'b1;
            cyc++;
        end
        check({tag, "_completed"}, {31'd0, done}, 32'd1);
        check({tag, "_req_in_done"}, {31'd0, MemReq}, 32'd0);
    endtask

    int st, rq;
    int sb_cyc, wr_cyc, rd_cyc, sb_stalls;
    bit sb_done;

    initial begin
        reset = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'd0; WriteDataM = 32'd0;
        MemRData = JUNK; MemReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        check("rst_stall", {31'd0, StallM}, 32'd0);
        check("rst_req",   {31'd0, MemReq}, 32'd0);
        check("rst_we",    {31'd0, MemWe},  32'd0);
        check("rst_addr",  MemAddr,  32'd0);
        check("rst_wdata", MemWData, 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        check("rst_err",   {31'd0, MemErr}, 32'd0);

        // Load, memory answers in first REQ cycle.
        do_access("ld1", 1'b1, 1'b0, 32'h0000_0104, 32'd0, 32'hCAFE_F00D, 0, st, rq);
        check("ld1_stalls", 32'(st), 32'd2);
        check("ld1_reqs",   32'(rq), 32'd1);
        check("ld1_rdata",  ReadDataM, 32'hCAFE_F00D);
        idle(1);

`ifndef STORE_BUFFER_EN
        // Misaligned store, three wait cycles.
        do_access("st1", 1'b0, 1'b1, 32'h0000_0023, 32'h1234_5678, 32'd0, 3, st, rq);
        check("st1_stalls", 32'(st), 32'd5);
        check("st1_reqs",   32'(rq), 32'd4);
        check("st1_rdata_held", ReadDataM, 32'hCAFE_F00D);
        idle(1);

        // Read and write together -> write.
        do_access("rw1", 1'b1, 1'b1, 32'h0000_0041, 32'hA5A5_A5A5, 32'h5555_5555, 0, st, rq);
        check("rw1_stalls", 32'(st), 32'd2);
        check("rw1_rdata_held", ReadDataM, 32'hCAFE_F00D);
        idle(1);
`endif

        // Back-to-back loads, second one seen right after DONE.
        do_access("bb1", 1'b1, 1'b0, 32'h0000_0200, 32'd0, 32'h1111_1111, 1, st, rq);
        check("bb1_stalls", 32'(st), 32'd3);
        check("bb1_reqs",   32'(rq), 32'd2);
        check("bb1_rdata",  ReadDataM, 32'h1111_1111);
        do_access("bb2", 1'b1, 1'b0, 32'h0000_0204, 32'd0, 32'h2222_2222, 0, st, rq);
        check("bb2_stalls", 32'(st), 32'd2);
        check("bb2_reqs",   32'(rq), 32'd1);
        check("bb2_rdata",  ReadDataM, 32'h2222_2222);
        idle(1);
        check("pre_to_err", {31'd0, MemErr}, 32'd0);

        // Timeout on a load that memory never answers.
        do_access("to1", 1'b1, 1'b0, 32'h0000_0300, 32'd0, 32'd0, -1, st, rq);
        check("to1_reqs",   32'(rq), 32'd4);
        check("to1_stalls", 32'(st), 32'd5);
        check("to1_err",    {31'd0, MemErr}, 32'd1);
        check("to1_rdata",  ReadDataM, 32'hDEAD_BEEF);
        idle(3);
        check("to1_err_sticky",   {31'd0, MemErr}, 32'd1);
        check("to1_rdata_sticky", ReadDataM, 32'hDEAD_BEEF);

        // Reset asserted in the second REQ cycle of a pending load.
        @(posedge clk); #1;
        MemReadM = 1'b1; ALUResultM = 32'h0000_0400; MemReady = 1'b0;
        @(negedge clk);
        check("rs_stall_t", {31'd0, StallM}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rs_req_pre", {31'd0, MemReq}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; MemReadM = 1'b0;
        @(negedge clk);
        check("rs_req",   {31'd0, MemReq}, 32'd0);
        check("rs_stall", {31'd0, StallM}, 32'd0);
        check("rs_rdata", ReadDataM, 32'd0);
        check("rs_err",   {31'd0, MemErr}, 32'd0);
        check("rs_addr",  MemAddr, 32'd0);
        do_access("rs_ld", 1'b1, 1'b0, 32'h0000_0404, 32'd0, 32'h0BAD_F00D, 0, st, rq);
        check("rs_ld_stalls", 32'(st), 32'd2);
        check("rs_ld_rdata",  ReadDataM, 32'h0BAD_F00D);
        idle(1);

`ifdef STORE_BUFFER_EN
        // Posted store then load; memory always answers in the first REQ cycle.
        @(posedge clk); #1;
        MemWriteM = 1'b1; MemReadM = 1'b0; ALUResultM = 32'h0000_0500;
        WriteDataM = 32'h55AA_55AA; MemReady = 1'b0;
        @(negedge clk);
        check("sb_store_stall", {31'd0, StallM}, 32'd0);
        sb_cyc = 1; wr_cyc = -1; rd_cyc = -1; sb_stalls = 0; sb_done = 1'b0;
        while (!sb_done && sb_cyc < 30) begin
            @(posedge clk); #1;
            MemWriteM = 1'b0; MemReadM = 1'b1; ALUResultM = 32'h0000_0504;
            MemReady = 1'b0; MemRData = JUNK;
            if (MemReq) begin
                MemReady = 1'b1; MemRData = 32'h7777_7777;
                if (MemWe && wr_cyc < 0) wr_cyc = sb_cyc;
                if (!MemWe && rd_cyc < 0) rd_cyc = sb_cyc;
            end
            @(negedge clk);
            if (StallM) sb_stalls++;
            else sb_done = 1'b1;
            sb_cyc++;
        end
        check("sb_done",   {31'd0, sb_done}, 32'd1);
        check("sb_stalls", 32'(sb_stalls), 32'd4);
        check("sb_wr_cyc", 32'(wr_cyc), 32'd1);
        check("sb_rd_cyc", 32'(rd_cyc), 32'd4);
        check("sb_rdata",  ReadDataM, 32'h7777_7777);
        idle(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
